// File: rtl/aes_avl_bridge.sv
// Avalon-MM register file that drives an AES decryption core and collects its result.
// Latency: register writes take effect on the next edge; AVL_READDATA is registered (1 cycle).
// Backpressure: none; the slave accepts every access and writes that are not allowed are dropped.
//
// Ports:
//   CLK, RESET              clock and asynchronous active-high reset
//   AVL_CS/READ/WRITE       Avalon-MM strobes; READ/WRITE are qualified by AVL_CS
//   AVL_ADDR, AVL_BYTE_EN   word address (16 registers) and write byte enables
//   AVL_WRITEDATA           write data
//   AVL_READDATA            registered read data
//   AES_START               level start request to the core
//   AES_KEY, AES_MSG_ENC    key and ciphertext to the core
//   AES_DONE, AES_MSG_DEC   core completion level and plaintext
//   EXPORT_DATA             {reg0[31:16], reg3[15:0]} for a hex display
module aes_avl_bridge #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         AVL_CS,
  input  logic         AVL_READ,
  input  logic         AVL_WRITE,
  input  logic [3:0]   AVL_ADDR,
  input  logic [3:0]   AVL_BYTE_EN,
  input  logic [31:0]  AVL_WRITEDATA,
  output logic [31:0]  AVL_READDATA,
  output logic         AES_START,
  output logic [127:0] AES_KEY,
  output logic [127:0] AES_MSG_ENC,
  input  logic         AES_DONE,
  input  logic [127:0] AES_MSG_DEC,
  output logic [31:0]  EXPORT_DATA
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [3:0] ADDR_CYCLES = 4'd12;
  localparam logic [3:0] ADDR_CTRL   = 4'd14;
  localparam logic [3:0] ADDR_STATUS = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Registers 0-7 (key then ciphertext) and 8-11 (captured plaintext).
  logic [31:0] kv_reg  [8];
  logic [31:0] dec_reg [4];

  logic             ctrl_start;
  logic             done_flag;
  logic             err_flag;
  logic             start_q;
  logic             start_nxt;
  logic [CNT_W-1:0] cyc_cnt;
  logic [31:0]      cnt_ext;
  logic [31:0]      rd_mux;

  // One-cycle strobes out of the FSM.
  logic go;
  logic capture;
  logic timeout;
  logic run_stay;

  logic busy;
  logic wr_en;
  logic kv_wr;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  assign busy  = (state == S_RUN);
  assign wr_en = AVL_CS & AVL_WRITE;
  // Key/ciphertext are frozen while the core is working on them.
  assign kv_wr = wr_en & ~AVL_ADDR[3] & ~busy;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_nxt = start_q;
    go        = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE: begin
        if (ctrl_start) begin
          state_nxt = S_RUN;
          start_nxt = 1'b1;
          go        = 1'b1;
        end
      end
      S_RUN: begin
        // Software abort wins over a completion arriving in the same cycle.
        if (!ctrl_start) begin
          state_nxt = S_IDLE;
          start_nxt = 1'b0;
        end else if (AES_DONE) begin
          state_nxt = S_HOLD;
          capture   = 1'b1;
        end else if (cyc_cnt == TO_LAST) begin
          state_nxt = S_HOLD;
          start_nxt = 1'b0;
          timeout   = 1'b1;
        end
      end
      S_HOLD: begin
        // After success the core keeps its result while START is held.
        if (!ctrl_start) begin
          state_nxt = S_IDLE;
          start_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        start_nxt = 1'b0;
      end
    endcase
  end

  // The completing/timing-out cycle does not count, so a timeout leaves
  // the counter at TIMEOUT_CYC-1.
  assign run_stay = (state == S_RUN) && (state_nxt == S_RUN);

  // ----------------------------------------------------------- datapath
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 8; i++) kv_reg[i] <= '0;
      for (int i = 0; i < 4; i++) dec_reg[i] <= '0;
      ctrl_start   <= 1'b0;
      done_flag    <= 1'b0;
      err_flag     <= 1'b0;
      start_q      <= 1'b0;
      cyc_cnt      <= '0;
      AVL_READDATA <= '0;
    end else begin
      if (kv_wr) begin
        kv_reg[AVL_ADDR[2:0]] <= byte_merge(kv_reg[AVL_ADDR[2:0]], AVL_WRITEDATA, AVL_BYTE_EN);
      end

      if (wr_en && (AVL_ADDR == ADDR_CTRL) && AVL_BYTE_EN[0]) begin
        ctrl_start <= AVL_WRITEDATA[0];
      end

      if (capture) begin
        dec_reg[0] <= AES_MSG_DEC[127:96];
        dec_reg[1] <= AES_MSG_DEC[95:64];
        dec_reg[2] <= AES_MSG_DEC[63:32];
        dec_reg[3] <= AES_MSG_DEC[31:0];
      end

      if (go) begin
        done_flag <= 1'b0;
        err_flag  <= 1'b0;
        cyc_cnt   <= '0;
      end else begin
        if (capture) done_flag <= 1'b1;
        if (timeout) err_flag  <= 1'b1;
        if (run_stay && (cyc_cnt != '1)) cyc_cnt <= cyc_cnt + CNT_ONE;
      end

      start_q <= start_nxt;

      // Reads sample the pre-edge register contents, so a same-cycle write
      // to the same address is not visible yet.
      if (AVL_CS && AVL_READ) begin
        AVL_READDATA <= rd_mux;
      end
    end
  end

  always_comb begin
    cnt_ext = '0;
    cnt_ext[CNT_W-1:0] = cyc_cnt;
  end

  always_comb begin
    rd_mux = '0;
    case (AVL_ADDR)
      4'd0, 4'd1, 4'd2, 4'd3,
      4'd4, 4'd5, 4'd6, 4'd7:  rd_mux = kv_reg[AVL_ADDR[2:0]];
      4'd8, 4'd9, 4'd10, 4'd11: rd_mux = dec_reg[AVL_ADDR[1:0]];
      ADDR_CYCLES:              rd_mux = cnt_ext;
      ADDR_CTRL:                rd_mux = {31'd0, ctrl_start};
      ADDR_STATUS:              rd_mux = {29'd0, busy, err_flag, done_flag};
      default:                  rd_mux = '0;
    endcase
  end

  // ------------------------------------------------------------ outputs
  assign AES_START   = start_q;
  assign AES_KEY     = {kv_reg[0], kv_reg[1], kv_reg[2], kv_reg[3]};
  assign AES_MSG_ENC = {kv_reg[4], kv_reg[5], kv_reg[6], kv_reg[7]};
  assign EXPORT_DATA = {kv_reg[0][31:16], kv_reg[3][15:0]};

endmodule

// File: tb/tb_aes_avl_bridge.sv
// Testbench for aes_avl_bridge with a behavioural AES core stub.
// Latency: stub raises AES_DONE a fixed number of cycles after seeing AES_START.
// Backpressure: not applicable; accesses are one per task call.
module tb_aes_avl_bridge;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_ENC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam int           STUB_LAT = 20;

  logic         CLK;
  logic         RESET;
  logic         AVL_CS;
  logic         AVL_READ;
  logic         AVL_WRITE;
  logic [3:0]   AVL_ADDR;
  logic [3:0]   AVL_BYTE_EN;
  logic [31:0]  AVL_WRITEDATA;
  logic [31:0]  AVL_READDATA;
  logic         AES_START;
  logic [127:0] AES_KEY;
  logic [127:0] AES_MSG_ENC;
  logic         AES_DONE;
  logic [127:0] AES_MSG_DEC;
  logic [31:0]  EXPORT_DATA;

  aes_avl_bridge #(.TIMEOUT_CYC(1024), .CNT_W(16)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .AVL_CS        (AVL_CS),
    .AVL_READ      (AVL_READ),
    .AVL_WRITE     (AVL_WRITE),
    .AVL_ADDR      (AVL_ADDR),
    .AVL_BYTE_EN   (AVL_BYTE_EN),
    .AVL_WRITEDATA (AVL_WRITEDATA),
    .AVL_READDATA  (AVL_READDATA),
    .AES_START     (AES_START),
    .AES_KEY       (AES_KEY),
    .AES_MSG_ENC   (AES_MSG_ENC),
    .AES_DONE      (AES_DONE),
    .AES_MSG_DEC   (AES_MSG_DEC),
    .EXPORT_DATA   (EXPORT_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Core stub: done STUB_LAT+1 edges after it first sees AES_START high,
  // held until AES_START drops; stub_en = 0 models a hung core.
  logic stub_en;
  logic stub_done;
  int   stub_cnt;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stub_done <= 1'b0;
      stub_cnt  <= 0;
    end else if (!AES_START) begin
      stub_done <= 1'b0;
      stub_cnt  <= 0;
    end else if (stub_en && stub_cnt == STUB_LAT) begin
      stub_done <= 1'b1;
    end else if (!stub_done) begin
      stub_cnt <= stub_cnt + 1;
    end
  end

  assign AES_DONE    = stub_done;
  assign AES_MSG_DEC = stub_done ? FIPS_PT : 128'd0;

  int n_cmp;
  int n_bad;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic avl_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge CLK);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    @(negedge CLK);
    AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_BYTE_EN = 4'h0;
  endtask

  task automatic avl_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge CLK);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
    @(negedge CLK);
    AVL_CS = 1'b0; AVL_READ = 1'b0;
    d = AVL_READDATA;
  endtask

  task automatic rd_check(input string nm, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    avl_rd(a, v);
    check(nm, {96'd0, v}, {96'd0, exp});
  endtask

  // Poll STATUS until DONE, bounded; an expired bound is a failed comparison.
  task automatic wait_done(input string nm);
    logic [31:0] v;
    logic        seen;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      avl_rd(4'd15, v);
      if (v[0]) seen = 1'b1;
    end
    check(nm, {127'd0, seen}, 128'd1);
  endtask

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit w, input logic [3:0] a, input logic [3:0] be,
                     input logic [31:0] d, input logic [31:0] e);
    vec_t r;
    r.is_wr = w; r.addr = a; r.be = be; r.data = d; r.exp = e;
    vt.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int          hi;
    n_cmp = 0; n_bad = 0;
    RESET = 1'b1; AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
    AVL_ADDR = 4'd0; AVL_BYTE_EN = 4'd0; AVL_WRITEDATA = 32'd0; stub_en = 1'b1;

    // ---- reset state
    repeat (3) @(negedge CLK);
    check("rst_start",    {127'd0, AES_START}, 128'd0);
    check("rst_readdata", {96'd0, AVL_READDATA}, 128'd0);
    check("rst_key",      AES_KEY, 128'd0);
    check("rst_export",   {96'd0, EXPORT_DATA}, 128'd0);
    RESET = 1'b0;
    rd_check("rst_status", 4'd15, 32'd0);

    // ---- register access vectors (idle)
    add(1, 4'd0,  4'b0101, 32'hFFFFFFFF, 32'h0);
    add(0, 4'd0,  4'b0000, 32'h0,        32'h00FF00FF);
    add(1, 4'd0,  4'b1111, 32'h00010203, 32'h0);
    add(1, 4'd1,  4'b1111, 32'hFFFFFFFF, 32'h0);
    add(1, 4'd1,  4'b0010, 32'h00112233, 32'h0);
    add(0, 4'd1,  4'b0000, 32'h0,        32'hFFFF22FF);
    add(1, 4'd1,  4'b1111, 32'h04050607, 32'h0);
    add(1, 4'd2,  4'b1111, 32'h08090a0b, 32'h0);
    add(1, 4'd3,  4'b1111, 32'h0c0d0e0f, 32'h0);
    add(1, 4'd4,  4'b1111, 32'h69c4e0d8, 32'h0);
    add(1, 4'd5,  4'b1111, 32'h6a7b0430, 32'h0);
    add(1, 4'd6,  4'b1111, 32'hd8cdb780, 32'h0);
    add(1, 4'd7,  4'b1111, 32'h70b4c55a, 32'h0);
    add(0, 4'd0,  4'b0000, 32'h0,        32'h00010203);
    add(0, 4'd3,  4'b0000, 32'h0,        32'h0c0d0e0f);
    add(0, 4'd6,  4'b0000, 32'h0,        32'hd8cdb780);
    add(1, 4'd13, 4'b1111, 32'h12345678, 32'h0);
    add(0, 4'd13, 4'b0000, 32'h0,        32'h0);
    add(1, 4'd9,  4'b1111, 32'hAAAAAAAA, 32'h0);
    add(0, 4'd9,  4'b0000, 32'h0,        32'h0);
    add(1, 4'd12, 4'b1111, 32'hFFFFFFFF, 32'h0);
    add(0, 4'd12, 4'b0000, 32'h0,        32'h0);
    add(1, 4'd15, 4'b1111, 32'h00000007, 32'h0);
    add(0, 4'd15, 4'b0000, 32'h0,        32'h0);
    add(1, 4'd14, 4'b1110, 32'h00000001, 32'h0);
    add(0, 4'd14, 4'b0000, 32'h0,        32'h0);
    add(0, 4'd15, 4'b0000, 32'h0,        32'h0);

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].is_wr) begin
        avl_wr(vt[i].addr, vt[i].data, vt[i].be);
      end else begin
        avl_rd(vt[i].addr, v);
        check($sformatf("vec%0d_addr%0d", i, vt[i].addr), {96'd0, v}, {96'd0, vt[i].exp});
      end
    end
    check("key_out",    AES_KEY, FIPS_KEY);
    check("enc_out",    AES_MSG_ENC, FIPS_ENC);
    check("export_out", {96'd0, EXPORT_DATA}, {96'd0, 32'h00010e0f});

    // ---- FIPS-197 run, with a dropped write while busy
    avl_wr(4'd14, 32'd1, 4'b0001);
    avl_wr(4'd4, 32'hDEADBEEF, 4'b1111);
    rd_check("busy_reg4", 4'd4, 32'h69c4e0d8);
    check("busy_enc_out", AES_MSG_ENC, FIPS_ENC);
    rd_check("busy_status", 4'd15, 32'h4);
    check("busy_start", {127'd0, AES_START}, 128'd1);
    wait_done("run1_done_seen");
    rd_check("run1_status", 4'd15, 32'h1);
    rd_check("run1_dec0", 4'd8,  32'h00112233);
    rd_check("run1_dec1", 4'd9,  32'h44556677);
    rd_check("run1_dec2", 4'd10, 32'h8899aabb);
    rd_check("run1_dec3", 4'd11, 32'hccddeeff);
    rd_check("run1_cycles", 4'd12, STUB_LAT + 1);
    check("hold_start", {127'd0, AES_START}, 128'd1);

    // ---- clear START, then restart
    avl_wr(4'd14, 32'd0, 4'b0001);
    rd_check("idle_status_keeps_done", 4'd15, 32'h1);
    check("idle_start", {127'd0, AES_START}, 128'd0);
    avl_wr(4'd14, 32'd1, 4'b0001);
    rd_check("run2_status_busy", 4'd15, 32'h4);
    wait_done("run2_done_seen");
    rd_check("run2_cycles", 4'd12, STUB_LAT + 1);
    rd_check("run2_dec3", 4'd11, 32'hccddeeff);
    avl_wr(4'd14, 32'd0, 4'b0001);

    // ---- software abort mid-run
    avl_wr(4'd14, 32'd1, 4'b0001);
    repeat (3) @(negedge CLK);
    avl_wr(4'd14, 32'd0, 4'b0001);
    rd_check("abort_status", 4'd15, 32'h0);
    check("abort_start", {127'd0, AES_START}, 128'd0);
    rd_check("abort_dec0_kept", 4'd8, 32'h00112233);

    // ---- timeout with a hung core
    stub_en = 1'b0;
    avl_wr(4'd14, 32'd1, 4'b0001);
    hi = 0;
    for (int k = 0; k < 1200; k++) begin
      @(posedge CLK); #1;
      if (AES_START) hi++;
      else if (hi > 0) break;
    end
    check("to_start_cycles", hi, 1024);
    check("to_start_low", {127'd0, AES_START}, 128'd0);
    rd_check("to_status", 4'd15, 32'h2);
    rd_check("to_cycles", 4'd12, 32'd1023);
    rd_check("to_dec0_kept", 4'd8, 32'h00112233);
    avl_wr(4'd14, 32'd0, 4'b0001);
    rd_check("to_status_after_clear", 4'd15, 32'h2);
    stub_en = 1'b1;

    // ---- asynchronous reset mid-run
    avl_wr(4'd14, 32'd1, 4'b0001);
    repeat (3) @(negedge CLK);
    check("pre_rst_start", {127'd0, AES_START}, 128'd1);
    RESET = 1'b1;
    #1;
    check("async_rst_start", {127'd0, AES_START}, 128'd0);
    @(negedge CLK);
    RESET = 1'b0;
    for (int a = 0; a < 16; a++) begin
      rd_check($sformatf("post_rst_reg%0d", a), a[3:0], 32'd0);
    end
    check("post_rst_key", AES_KEY, 128'd0);
    check("post_rst_export", {96'd0, EXPORT_DATA}, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
